shift_right: RTL and testbench

- Registered logical right shifter for 23-bit floating-point mantissas. Used to align the smaller operand's significand before FP add/sub.
- Shift amount is an 8-bit exponent difference. Result appears one clock after the input is accepted.
- Optionally produces IEEE guard/round/sticky bits for the following rounding stage.

---
 rtl/shift_right_if.sv | 27 ++
 rtl/shift_right.sv | 83 ++++++++
 tb/tb_shift_right.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/shift_right_if.sv
// Handshake/data bundle for the shift_right mantissa aligner.
// The master drives operands and in_valid; the slave returns the registered result.
interface shift_right_if #(
  parameter int WIDTH = 23,
  parameter int QTT_W = 8
);
  // Handshake: in_valid qualifies num/shiftRightQtt for one clock and is always
  // accepted (no ready). out_valid is high for exactly the cycle after acceptance.
  logic             in_valid;
  logic [WIDTH-1:0] num;
  logic [QTT_W-1:0] shiftRightQtt;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             guard;
  logic             round_bit;
  logic             sticky;

  modport master (
    output in_valid, num, shiftRightQtt,
    input  out_valid, result, guard, round_bit, sticky
  );

  modport slave (
    input  in_valid, num, shiftRightQtt,
    output out_valid, result, guard, round_bit, sticky
  );
endinterface

// File: rtl/shift_right.sv
// Registered logical right shifter for FP mantissa alignment, 1-cycle latency.
// Define SHIFT_RIGHT_GRS_EN to build guard/round/sticky outputs; otherwise they are tied to 0.
module shift_right #(
  parameter int WIDTH = 23,
  parameter int QTT_W = 8
) (
  input logic      clk,
  input logic      rst,
  shift_right_if.slave bus
);

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;

`ifdef SHIFT_RIGHT_GRS_EN
  // Two extra LSBs catch guard and round; everything falling below them ORs into sticky.
  localparam int E = WIDTH + 2;

  logic [E-1:0] ext;
  logic         stk;
  logic         guard_q, round_q, sticky_q;

  always_comb begin
    ext = {bus.num, 2'b00};
    stk = 1'b0;
    for (int i = 0; i < QTT_W; i++) begin
      if (bus.shiftRightQtt[i]) begin
        stk = stk | (|(ext & ~({E{1'b1}} << (1 << i))));
        ext = ext >> (1 << i);
      end
    end
    result_d = ext[E-1:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      guard_q     <= 1'b0;
      round_q     <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q <= result_d;
        guard_q  <= ext[1];
        round_q  <= ext[0];
        sticky_q <= stk;
      end
    end
  end

  assign bus.guard     = guard_q;
  assign bus.round_bit = round_q;
  assign bus.sticky    = sticky_q;
`else
  // Shift amounts >= WIDTH naturally produce zero; no wrap on the 8-bit amount.
  always_comb begin
    result_d = bus.num >> bus.shiftRightQtt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q <= result_d;
      end
    end
  end

  assign bus.guard     = 1'b0;
  assign bus.round_bit = 1'b0;
  assign bus.sticky    = 1'b0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_shift_right.sv
// Scoreboard bench for shift_right: directed boundary cases plus randomized stream.
// Expectations come from a bit-level reference of the shift/GRS rules.
module tb_shift_right;
  localparam int WIDTH = 23;
  localparam int QTT_W = 8;
  localparam int EW    = WIDTH + 3;

  logic clk;
  logic rst;

  shift_right_if #(.WIDTH(WIDTH), .QTT_W(QTT_W)) bus ();

  shift_right #(.WIDTH(WIDTH), .QTT_W(QTT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  int vectors;
  int miscompares;

  // ---------------- reference model ----------------
  function automatic logic nb(input logic [WIDTH-1:0] n, input int idx);
    if (idx >= 0 && idx < WIDTH) return n[idx];
    return 1'b0;
  endfunction

  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] n, input int q);
    logic [WIDTH-1:0] res;
    logic g, r, s;
    for (int j = 0; j < WIDTH; j++) res[j] = nb(n, j + q);
    g = 1'b0; r = 1'b0; s = 1'b0;
`ifdef SHIFT_RIGHT_GRS_EN
    if (q >= 1) g = nb(n, q - 1);
    if (q >= 2) r = nb(n, q - 2);
    for (int k = 0; k <= q - 3; k++) s = s | nb(n, k);
`endif
    return {res, g, r, s};
  endfunction

  function automatic logic [EW-1:0] dut_word();
    return {bus.result, bus.guard, bus.round_bit, bus.sticky};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got res=%06h g=%0b r=%0b s=%0b, want res=%06h g=%0b r=%0b s=%0b",
               name, act[EW-1:3], act[2], act[1], act[0], req[EW-1:3], req[2], req[1], req[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0b, want %0b", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [WIDTH-1:0] n, input int q);
    @(posedge clk); #1;
    bus.in_valid      = 1'b1;
    bus.num           = n;
    bus.shiftRightQtt = QTT_W'(q);
    exp_q.push_back(model(n, q));
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.num      = WIDTH'($urandom);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_bit("unexpected_out_valid", 1'b1, 1'b0);
        end else begin
          last_exp = exp_q.pop_front();
          check("result", dut_word(), last_exp);
        end
      end else begin
        check_bit("out_valid_low", bus.out_valid, 1'b0);
        check("hold", dut_word(), last_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    last_exp    = '0;
    rst               = 1'b0;
    bus.in_valid      = 1'b1;
    bus.num           = 23'h7FFFFF;
    bus.shiftRightQtt = 8'd3;

    // reset asserted with valid input present
    #1 rst = 1'b1;
    #1;
    check("reset_async", dut_word(), '0);
    check_bit("reset_async_valid", bus.out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", dut_word(), '0);
    check_bit("reset_held_valid", bus.out_valid, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    // directed cases
    issue(23'h700000, 6);
    issue(23'h00000F, 2);
    issue(23'h5A5A5A, 0);
    issue(23'h400001, 22);
    issue(23'h400000, 23);
    issue(23'h3FFFFF, 23);
    issue(23'h000001, 255);
    issue(23'h7FFFFF, 24);
    issue(23'h7FFFFF, 25);
    issue(23'h7FFFFF, 26);
    issue(23'h7FFFFF, 128);
    idle(2);

    // streaming then hold
    issue(23'h7FFFFF, 1);
    issue(23'h7FFFFF, 2);
    issue(23'h7FFFFF, 3);
    idle(3);

    // reset the cycle after an accepted input
    issue(23'h123456, 4);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_bit("midop_reset_valid", bus.out_valid, 1'b0);
    check("midop_reset_data", dut_word(), '0);
    exp_q.delete();
    last_exp = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // randomized stream with gaps
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        issue(WIDTH'($urandom),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 27)));
      end
    end
    idle(4);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
